// File: rtl/iomem_rr_arbiter.sv
// Round-robin arbiter and sequencer for the shared iomem bus.
// Three requesters share the bus: icache refill (0), dcache refill/writeback (1)
// and debug/DMA (2). One block transaction is in flight at a time. The bus fields
// are latched at grant time and held until iomem_ready. A transaction that gets
// no answer within TIMEOUT_CYC busy cycles completes with req_err_o set.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_valid_i/addr/wstrb/wdata  packed per-requester request fields
//   req_ready_o, req_err_o one-hot completion pulse and its error flag
//   rsp_rdata_o            read block captured at completion
//   iomem_*                shared memory bus
//   grant_o, busy_o        current/last grant index, non-idle indication
module iomem_rr_arbiter #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BLK_SIZE    = 128,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [2:0]            req_valid_i,
  input  logic [3*XLEN-1:0]     req_addr_i,
  input  logic [3*16-1:0]       req_wstrb_i,
  input  logic [3*BLK_SIZE-1:0] req_wdata_i,
  output logic [2:0]            req_ready_o,
  output logic                  req_err_o,
  output logic [BLK_SIZE-1:0]   rsp_rdata_o,
  output logic                  iomem_valid,
  input  logic                  iomem_ready,
  output logic [XLEN-1:0]       iomem_addr,
  output logic [15:0]           iomem_wstrb,
  output logic [BLK_SIZE-1:0]   iomem_wdata,
  input  logic [BLK_SIZE-1:0]   iomem_rdata,
  output logic [1:0]            grant_o,
  output logic                  busy_o
);

  localparam int unsigned NREQ   = 3;
  localparam int unsigned STRB_W = 16;
  localparam int unsigned CNT_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          grant_q, grant_d;
  logic                valid_q, valid_d;
  logic [XLEN-1:0]     addr_q, addr_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [BLK_SIZE-1:0] wdata_q, wdata_d;
  logic [NREQ-1:0]     ready_q, ready_d;
  logic                err_q, err_d;
  logic [BLK_SIZE-1:0] rdata_q, rdata_d;
  logic                busy_q, busy_d;

  logic [1:0]          win_c;
  logic [XLEN-1:0]     sel_addr_c;
  logic [STRB_W-1:0]   sel_wstrb_c;
  logic [BLK_SIZE-1:0] sel_wdata_c;

  // Round-robin pick: search starts one past the last grant and wraps 0,1,2.
  always_comb begin
    win_c = grant_q;
    case (grant_q)
      2'd0: begin
        if (req_valid_i[1])      win_c = 2'd1;
        else if (req_valid_i[2]) win_c = 2'd2;
        else                     win_c = 2'd0;
      end
      2'd1: begin
        if (req_valid_i[2])      win_c = 2'd2;
        else if (req_valid_i[0]) win_c = 2'd0;
        else                     win_c = 2'd1;
      end
      default: begin
        if (req_valid_i[0])      win_c = 2'd0;
        else if (req_valid_i[1]) win_c = 2'd1;
        else                     win_c = 2'd2;
      end
    endcase
  end

  // Winner's request fields.
  always_comb begin
    sel_addr_c  = '0;
    sel_wstrb_c = '0;
    sel_wdata_c = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_c == 2'(i)) begin
        sel_addr_c  = req_addr_i[i*XLEN +: XLEN];
        sel_wstrb_c = req_wstrb_i[i*STRB_W +: STRB_W];
        sel_wdata_c = req_wdata_i[i*BLK_SIZE +: BLK_SIZE];
      end
    end
  end

  // Next-state and next-output logic; completion flags default low so the
  // ready/err pulse lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;
    ready_d = '0;
    err_d   = 1'b0;
    rdata_d = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (|req_valid_i) begin
          grant_d = win_c;
          addr_d  = sel_addr_c;
          wstrb_d = sel_wstrb_c;
          wdata_d = sel_wdata_c;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A ready that coincides with the last allowed cycle still succeeds.
        if (iomem_ready) begin
          rdata_d = iomem_rdata;
          valid_d = 1'b0;
          ready_d = NREQ'(3'b001 << grant_q);
          state_d = ST_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          rdata_d = '0;
          valid_d = 1'b0;
          err_d   = 1'b1;
          ready_d = NREQ'(3'b001 << grant_q);
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      grant_q <= 2'd2;
      valid_q <= 1'b0;
      addr_q  <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
      ready_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
    end
  end

  assign req_ready_o = ready_q;
  assign req_err_o   = err_q;
  assign rsp_rdata_o = rdata_q;
  assign iomem_valid = valid_q;
  assign iomem_addr  = addr_q;
  assign iomem_wstrb = wstrb_q;
  assign iomem_wdata = wdata_q;
  assign grant_o     = grant_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_iomem_rr_arbiter.sv
// Directed bench for iomem_rr_arbiter with TIMEOUT_CYC=8.
module tb_iomem_rr_arbiter;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BLK  = 128;
  localparam int unsigned TO   = 8;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic [2:0]      req_valid_i = '0;
  logic [3*XLEN-1:0] req_addr_i = '0;
  logic [3*16-1:0] req_wstrb_i = '0;
  logic [3*BLK-1:0] req_wdata_i = '0;
  logic [2:0]      req_ready_o;
  logic            req_err_o;
  logic [BLK-1:0]  rsp_rdata_o;
  logic            iomem_valid;
  logic            iomem_ready = 1'b0;
  logic [XLEN-1:0] iomem_addr;
  logic [15:0]     iomem_wstrb;
  logic [BLK-1:0]  iomem_wdata;
  logic [BLK-1:0]  iomem_rdata = '0;
  logic [1:0]      grant_o;
  logic            busy_o;

  int n_pass  = 0;
  int n_total = 0;

  localparam logic [BLK-1:0] RD_A = 128'hDEADBEEF_CAFEF00D_89ABCDEF_01230123;
  localparam logic [BLK-1:0] RD_5 = {16{8'h55}};

  iomem_rr_arbiter #(.XLEN(XLEN), .BLK_SIZE(BLK), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_addr_i(req_addr_i),
    .req_wstrb_i(req_wstrb_i), .req_wdata_i(req_wdata_i),
    .req_ready_o(req_ready_o), .req_err_o(req_err_o), .rsp_rdata_o(rsp_rdata_o),
    .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
    .iomem_addr(iomem_addr), .iomem_wstrb(iomem_wstrb), .iomem_wdata(iomem_wdata),
    .iomem_rdata(iomem_rdata), .grant_o(grant_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one clock edge and settle past it.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    req_valid_i = '0;
    do_reset();
    n_total++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_o); else n_pass++;
    n_total++; if (iomem_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", iomem_valid); else n_pass++;
    n_total++; if (grant_o !== 2'd2) $display("FAIL reset_grant: got %0d want 2", grant_o); else n_pass++;
    n_total++; if (req_ready_o !== 3'b000 || req_err_o !== 1'b0)
      $display("FAIL reset_ready: got %b/%b want 000/0", req_ready_o, req_err_o); else n_pass++;
    n_total++; if (rsp_rdata_o !== '0 || iomem_addr !== '0)
      $display("FAIL reset_data: got %h/%h want 0", rsp_rdata_o, iomem_addr); else n_pass++;
  endtask

  task automatic test_contention();
    logic [1:0] exp_g [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    do_reset();
    req_addr_i  = {32'h2000_0000, 32'h1000_0000, 32'h0000_1000};
    req_valid_i = 3'b111;
    for (int t = 0; t < 6; t++) begin
      step();
      n_total++; if (grant_o !== exp_g[t] || iomem_valid !== 1'b1)
        $display("FAIL rot_grant[%0d]: got %0d/%b want %0d/1", t, grant_o, iomem_valid, exp_g[t]); else n_pass++;
      n_total++; if (iomem_addr !== req_addr_i[exp_g[t]*XLEN +: XLEN])
        $display("FAIL rot_addr[%0d]: got %h", t, iomem_addr); else n_pass++;
      iomem_ready = 1'b1;
      iomem_rdata = BLK'(t);
      step();
      iomem_ready = 1'b0;
      n_total++; if (req_ready_o !== (3'b001 << exp_g[t]) || rsp_rdata_o !== BLK'(t))
        $display("FAIL rot_ready[%0d]: got %b/%h want %b/%0d", t, req_ready_o, rsp_rdata_o, 3'b001 << exp_g[t], t); else n_pass++;
      step();
    end
    req_valid_i = '0;
  endtask

  task automatic test_single_read();
    req_addr_i[0 +: XLEN] = 32'h8000_0010;
    req_wstrb_i = '0;
    req_valid_i = 3'b001;
    step();  // cycle 0 edge: granted
    n_total++; if (iomem_valid !== 1'b1 || iomem_addr !== 32'h8000_0010 || iomem_wstrb !== 16'h0)
      $display("FAIL rd_issue: got v=%b a=%h s=%h want 1/80000010/0", iomem_valid, iomem_addr, iomem_wstrb); else n_pass++;
    n_total++; if (grant_o !== 2'd0 || busy_o !== 1'b1)
      $display("FAIL rd_grant: got %0d/%b want 0/1", grant_o, busy_o); else n_pass++;
    req_valid_i = 3'b000;
    step();
    n_total++; if (iomem_valid !== 1'b1 || req_ready_o !== 3'b000)
      $display("FAIL rd_hold: got %b/%b want 1/000", iomem_valid, req_ready_o); else n_pass++;
    iomem_ready = 1'b1;
    iomem_rdata = RD_A;
    step();
    iomem_ready = 1'b0;
    n_total++; if (req_ready_o !== 3'b001 || req_err_o !== 1'b0 || rsp_rdata_o !== RD_A || iomem_valid !== 1'b0)
      $display("FAIL rd_done: got r=%b e=%b d=%h v=%b", req_ready_o, req_err_o, rsp_rdata_o, iomem_valid); else n_pass++;
    step();
    n_total++; if (busy_o !== 1'b0 || req_ready_o !== 3'b000 || rsp_rdata_o !== RD_A)
      $display("FAIL rd_idle: got b=%b r=%b d=%h", busy_o, req_ready_o, rsp_rdata_o); else n_pass++;
  endtask

  task automatic test_timeout();
    int vcnt;
    req_addr_i[XLEN +: XLEN] = 32'h4000_0040;
    req_wstrb_i[16 +: 16] = 16'hFFFF;
    req_wdata_i[BLK +: BLK] = {4{32'hA5A5_0001}};
    req_valid_i = 3'b010;
    step();
    req_valid_i = 3'b000;
    vcnt = 0;
    for (int c = 0; c < 20 && iomem_valid === 1'b1; c++) begin
      vcnt++;
      n_total++; if (req_ready_o !== 3'b000)
        $display("FAIL to_early_ready: got %b at busy cycle %0d", req_ready_o, c); else n_pass++;
      if (c < 20) step();
    end
    n_total++; if (vcnt != 8) $display("FAIL to_valid_len: got %0d want 8", vcnt); else n_pass++;
    n_total++; if (req_ready_o !== 3'b010 || req_err_o !== 1'b1 || rsp_rdata_o !== '0)
      $display("FAIL to_abort: got r=%b e=%b d=%h want 010/1/0", req_ready_o, req_err_o, rsp_rdata_o); else n_pass++;
    req_addr_i[2*XLEN +: XLEN] = 32'h6000_0000;
    req_valid_i = 3'b100;
    step();  // RESP -> IDLE
    step();  // grant req 2
    req_valid_i = 3'b000;
    n_total++; if (grant_o !== 2'd2 || iomem_addr !== 32'h6000_0000 || req_err_o !== 1'b0)
      $display("FAIL to_next_grant: got %0d/%h/%b", grant_o, iomem_addr, req_err_o); else n_pass++;
    iomem_ready = 1'b1;
    iomem_rdata = RD_A;
    step();
    iomem_ready = 1'b0;
    n_total++; if (req_ready_o !== 3'b100 || req_err_o !== 1'b0 || rsp_rdata_o !== RD_A)
      $display("FAIL to_next_done: got %b/%b/%h", req_ready_o, req_err_o, rsp_rdata_o); else n_pass++;
    step();
  endtask

  task automatic test_tie();
    req_valid_i = 3'b001;
    step();
    req_valid_i = 3'b000;
    for (int c = 0; c < 7; c++) step();
    n_total++; if (iomem_valid !== 1'b1 || req_ready_o !== 3'b000)
      $display("FAIL tie_pre: got %b/%b want 1/000", iomem_valid, req_ready_o); else n_pass++;
    iomem_ready = 1'b1;
    iomem_rdata = RD_5;
    step();
    iomem_ready = 1'b0;
    n_total++; if (req_ready_o !== 3'b001 || req_err_o !== 1'b0 || rsp_rdata_o !== RD_5)
      $display("FAIL tie_done: got r=%b e=%b d=%h", req_ready_o, req_err_o, rsp_rdata_o); else n_pass++;
    step();
  endtask

  task automatic test_field_stability();
    req_addr_i  = {32'h2222_0000, 32'h1111_0000, 32'h0BAD_0100};
    req_wstrb_i = {16'h0F0F, 16'h00FF, 16'hF00F};
    req_wdata_i = {{4{32'h2}}, {4{32'h1}}, {4{32'h1234_5678}}};
    req_valid_i = 3'b001;
    step();
    for (int c = 0; c < 4; c++) begin
      req_addr_i  = {$urandom, $urandom, $urandom};
      req_wdata_i = {12{$urandom}};
      req_valid_i = 3'b101;
      step();
      n_total++; if (iomem_addr !== 32'h0BAD_0100 || iomem_wstrb !== 16'hF00F ||
                     iomem_wdata !== {4{32'h1234_5678}} || grant_o !== 2'd0)
        $display("FAIL fs_hold[%0d]: got a=%h s=%h g=%0d", c, iomem_addr, iomem_wstrb, grant_o); else n_pass++;
    end
    iomem_ready = 1'b1;
    step();
    iomem_ready = 1'b0;
    n_total++; if (req_ready_o !== 3'b001) $display("FAIL fs_done: got %b want 001", req_ready_o); else n_pass++;
    req_addr_i[2*XLEN +: XLEN] = 32'h7777_0000;
    step();
    n_total++; if (busy_o !== 1'b0) $display("FAIL fs_idle: got %b want 0", busy_o); else n_pass++;
    step();
    req_valid_i = 3'b000;
    n_total++; if (grant_o !== 2'd2 || iomem_addr !== 32'h7777_0000)
      $display("FAIL fs_late_req2: got %0d/%h want 2/77770000", grant_o, iomem_addr); else n_pass++;
    iomem_ready = 1'b1;
    step();
    iomem_ready = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    req_valid_i = 3'b010;
    step();
    n_total++; if (iomem_valid !== 1'b1 || grant_o !== 2'd1)
      $display("FAIL ar_busy: got %b/%0d want 1/1", iomem_valid, grant_o); else n_pass++;
    #2 rst_ni = 1'b0;
    #1;
    n_total++; if (iomem_valid !== 1'b0 || busy_o !== 1'b0 || grant_o !== 2'd2)
      $display("FAIL ar_drop: got v=%b b=%b g=%0d want 0/0/2", iomem_valid, busy_o, grant_o); else n_pass++;
    iomem_ready = 1'b1;
    step();
    iomem_ready = 1'b0;
    n_total++; if (req_ready_o !== 3'b000) $display("FAIL ar_no_pulse: got %b want 000", req_ready_o); else n_pass++;
    #2 rst_ni = 1'b1;
    req_valid_i = 3'b011;
    step();
    n_total++; if (grant_o !== 2'd0 || iomem_valid !== 1'b1)
      $display("FAIL ar_after: got %0d/%b want 0/1", grant_o, iomem_valid); else n_pass++;
    req_valid_i = 3'b000;
    iomem_ready = 1'b1;
    step();
    iomem_ready = 1'b0;
    n_total++; if (req_ready_o !== 3'b001) $display("FAIL ar_after_done: got %b want 001", req_ready_o); else n_pass++;
    step();
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single_read();
    test_timeout();
    test_tie();
    test_field_stability();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/iomem_rr_arbiter.md
Name: iomem_rr_arbiter

Overview:
- Three-requester round-robin arbiter and sequencer for the shared iomem bus. Requesters are instruction-cache refill (req 0), data-cache refill/writeback (req 1) and a debug/DMA port (req 2).
- Serialises one block transaction at a time and holds the bus fields stable until `iomem_ready`.
- Aborts with an error response if memory does not answer within a bounded number of cycles.
- Sits between the cache lowX request/response ports and the `cpu` iomem outputs.

Parameters:
- XLEN, 32, address width.
- BLK_SIZE, 128, data block width in bits.
- TIMEOUT_CYC, 256, maximum cycles in BUSY before abort (≥2).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  3  per-requester request valid; bit0=icache, bit1=dcache, bit2=debug.
- req_addr_i  in  3*XLEN  per-requester address, packed; requester n at [n*XLEN +: XLEN].
- req_wstrb_i  in  3*16  per-requester byte write strobes; 0 = read.
- req_wdata_i  in  3*BLK_SIZE  per-requester write block.
- req_ready_o  out  3  one-hot, one-cycle completion pulse to the granted requester.
- req_err_o  out  1  valid with req_ready_o; 1 = timeout abort.
- rsp_rdata_o  out  BLK_SIZE  read block, valid with req_ready_o; shared by all requesters.
- iomem_valid  out  1  bus request valid.
- iomem_ready  in  1  memory completion.
- iomem_addr  out  XLEN  bus address.
- iomem_wstrb  out  16  bus write strobes.
- iomem_wdata  out  BLK_SIZE  bus write data.
- iomem_rdata  in  BLK_SIZE  bus read data.
- grant_o  out  2  index of the current/last granted requester.
- busy_o  out  1  high when state != IDLE.

Behaviour:
- **Reset values** (asynchronous, all flops):
  - state=IDLE, iomem_valid=0, iomem_addr/wstrb/wdata=0.
  - req_ready_o=0, req_err_o=0, rsp_rdata_o=0.
  - last_grant=2 (so req 0 wins the first contention), grant_o=2, timeout counter=0.
  - Reset mid-transaction drops iomem_valid immediately and no completion pulse is issued.
- **All outputs are registered.**
- **FSM states:** IDLE, BUSY, RESP.
- **IDLE:**
  - If `|req_valid_i`, select the first asserted requester searching from (last_grant+1) mod 3, wrapping over indices 0,1,2.
  - Latch that requester's addr/wstrb/wdata into the iomem_* registers; set iomem_valid=1, grant_o and last_grant to the winner, counter=0; go to BUSY.
  - No requests: remain in IDLE.
- **BUSY:**
  - iomem_valid=1; addr/wstrb/wdata held constant regardless of changes on req_* inputs.
  - Counter increments each cycle.
  - iomem_ready=1: capture iomem_rdata into rsp_rdata_o, iomem_valid←0, req_err_o←0, req_ready_o[grant]←1; go to RESP.
  - Else if counter==TIMEOUT_CYC-1: iomem_valid←0, rsp_rdata_o←0, req_err_o←1, req_ready_o[grant]←1; go to RESP.
  - iomem_ready and timeout in the same cycle: ready wins, err=0.
- **RESP:**
  - Pulse is visible for exactly this one cycle; req_ready_o←0 and req_err_o←0 on exit; go to IDLE.
  - rsp_rdata_o holds its value until the next capture.
- **Requester rule:** req_valid_i is sampled only in IDLE. A requester that saw its ready pulse must present its next intent (new request or 0) by the IDLE cycle that follows. Valid may drop while BUSY without effect; the transaction completes normally.
- **Bus rules:**
  - iomem_ready while iomem_valid=0 is ignored.
  - Exactly one transaction is outstanding at a time.
- **Latency:**
  - Request seen in IDLE at cycle 0 → iomem_valid at cycle 1.
  - iomem_ready at cycle k (k≥1) → req_ready_o at k+1 → IDLE at k+2.
  - Minimum turnaround is 3 cycles per transaction.
- **Fairness:** with all requesters continuously valid, grants rotate 0,1,2,0,… Worst-case wait is 2 transactions.
- **wstrb:** passed through unmodified; the arbiter does not interpret read vs. write except via data capture (rdata is captured for writes too).

Test Plan:
- **Single read:** reset, then req_valid_i=3'b001, addr=0x8000_0010, wstrb=0; memory asserts ready 2 cycles after valid with rdata=0xDEADBEEF_…_0123 → iomem_valid cycles 1–2, req_ready_o=3'b001 at cycle 3 with that rdata, req_err_o=0, busy_o low at cycle 4.
- **Contention rotation:** hold req_valid_i=3'b111 after reset with ready 1 cycle after valid → grant_o sequence 0,1,2,0,1,2; each ready pulse one-hot to the matching requester.
- **Timeout:** TIMEOUT_CYC=8, req 1 write wstrb=16'hFFFF, never assert ready → iomem_valid high exactly 8 cycles, then req_ready_o=3'b010, req_err_o=1, rsp_rdata_o=0; next request from req 2 is served normally.
- **Ready/timeout tie:** TIMEOUT_CYC=8, ready on the 8th BUSY cycle with rdata=0x55…55 → req_err_o=0, rsp_rdata_o=0x55…55.
- **Field stability:** during BUSY, toggle req_addr_i/req_wdata_i of the granted and other requesters every cycle → iomem_addr/wdata/wstrb constant until completion; late-arriving req 2 is served only after RESP.
- **Async reset mid-BUSY:** assert rst_ni=0 between clock edges while BUSY → iomem_valid=0 and busy_o=0 immediately, with no req_ready_o pulse; after release, req 0 wins contention against req 1.
